// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the chunk-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of chunks processed per operation.
   function automatic int unsigned nchunk(input int unsigned data_w, input int unsigned chunk_w);
      return data_w / chunk_w;
   endfunction

   // Index register width; at least one bit so NCHUNK=1 still has a counter.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Widths are legal only when the operand splits into whole, non-empty chunks.
   function automatic bit chunk_cfg_ok(input int unsigned data_w, input int unsigned chunk_w);
      return (chunk_w != 0) && (data_w >= chunk_w) && ((data_w % chunk_w) == 0);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: Diff = X - Y - Bin, Bout set when the bit borrows.
module full_subtractor (
   input  logic X,
   input  logic Y,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = X ^ Y ^ Bin;
   assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Chunk-serial two's-complement subtractor D = A - B - Bi, LSB chunk first.
// Optional signed-overflow output V is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CHUNK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  Bi,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] D,
   output logic                  Bo
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic                  V
`endif
);

   localparam int unsigned NCHUNK = nchunk(DATA_WIDTH, CHUNK_WIDTH);
   localparam int unsigned IDX_W  = idx_width(NCHUNK);
   localparam int unsigned BASE_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   if (!chunk_cfg_ok(DATA_WIDTH, CHUNK_WIDTH)) begin : g_bad_cfg
      $error("serial_subtractor: DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
   end

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   a_q;
   logic [DATA_WIDTH-1:0]   b_q;
   logic [DATA_WIDTH-1:0]   d_q;
   logic                    borrow_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    bo_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic                    v_q;
`endif

   logic [BASE_W-1:0]       base_c;
   logic [CHUNK_WIDTH-1:0]  a_chunk_c;
   logic [CHUNK_WIDTH-1:0]  b_chunk_c;
   logic [CHUNK_WIDTH-1:0]  diff_d;
   logic [CHUNK_WIDTH:0]    bchain_c;
   logic                    borrow_d;

   // Select the active chunk of each operand.
   assign base_c    = BASE_W'(idx_q) * BASE_W'(CHUNK_WIDTH);
   assign a_chunk_c = a_q[base_c +: CHUNK_WIDTH];
   assign b_chunk_c = b_q[base_c +: CHUNK_WIDTH];

   // Ripple-borrow chain across one chunk, seeded by the inter-chunk borrow.
   assign bchain_c[0] = borrow_q;
   for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_fs
      full_subtractor u_fs (
         .X    (a_chunk_c[i]),
         .Y    (b_chunk_c[i]),
         .Bin  (bchain_c[i]),
         .Diff (diff_d[i]),
         .Bout (bchain_c[i+1])
      );
   end
   assign borrow_d = bchain_c[CHUNK_WIDTH];

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         d_q         <= '0;
         borrow_q    <= 1'b0;
         idx_q       <= '0;
         bo_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         v_q         <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= A;
                  b_q        <= B;
                  borrow_q   <= Bi;
                  idx_q      <= '0;
                  d_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               d_q[base_c +: CHUNK_WIDTH] <= diff_d;
               borrow_q <= borrow_d;
               idx_q    <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  bo_q        <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  v_q         <= (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                                 (diff_d[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign D         = d_q;
   assign Bo        = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign V         = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor: a 32/8 instance and a 32/32 instance.
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        v;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [1:0]  bi;
   logic [1:0]  bo;
   logic [1:0]  v;
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic [31:0] d [2];

   int   total;
   int   bad;
   exp_t sb [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_subtractor #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .A         (a[0]),
      .B         (b[0]),
      .Bi        (bi[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .D         (d[0]),
      .Bo        (bo[0])
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .V         (v[0])
`endif
   );

   serial_subtractor #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .A         (a[1]),
      .B         (b[1]),
      .Bi        (bi[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .D         (d[1]),
      .Bo        (bo[1])
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .V         (v[1])
`endif
   );

`ifndef SERIAL_SUB_OVERFLOW_EN
   assign v = 2'b00;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation on instance s, hold off the consumer for 'hold' cycles, then drain.
   task automatic do_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic biv, input int hold);
      exp_t        e;
      logic [32:0] r;
      int          lat;
      r    = {1'b0, av} - {1'b0, bv} - 33'(biv);
      e.d  = r[31:0];
      e.bo = r[32];
      e.v  = (av[31] != bv[31]) && (r[31] != av[31]);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready[s]), 64'd1);
      in_valid[s] = 1'b1;
      a[s]        = av;
      b[s]        = bv;
      bi[s]       = biv;
      sb.push_back(e);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid[s] = 1'b0;
      a[s]        = ~av;
      b[s]        = 32'h0;
      bi[s]       = ~biv;
      check("in_ready_run", 64'(in_ready[s]), 64'd0);
      while (out_valid[s] !== 1'b1 && lat < 64) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 64'(lat), (s == 0) ? 64'd5 : 64'd2);
      e = sb.pop_front();
      for (int i = 0; i <= hold; i++) begin
         check("d", 64'(d[s]), 64'(e.d));
         check("bo", 64'(bo[s]), 64'(e.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
         check("v", 64'(v[s]), 64'(e.v));
`endif
         check("out_valid_hold", 64'(out_valid[s]), 64'd1);
         check("in_ready_hold", 64'(in_ready[s]), 64'd0);
         if (i < hold) begin
            in_valid[s] = 1'b1;
            a[s]        = $urandom;
            b[s]        = $urandom;
            @(posedge clk);
            @(negedge clk);
         end
      end
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[s] = 1'b0;
      check("out_valid_fall", 64'(out_valid[s]), 64'd0);
      check("in_ready_rise", 64'(in_ready[s]), 64'd1);
      check("d_after", 64'(d[s]), 64'(e.d));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset_n   = 1'b0;
      in_valid  = 2'b00;
      out_ready = 2'b00;
      bi        = 2'b00;
      a[0] = '0; a[1] = '0;
      b[0] = '0; b[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset state of both instances.
      for (int s = 0; s < 2; s++) begin
         check("rst_in_ready", 64'(in_ready[s]), 64'd1);
         check("rst_out_valid", 64'(out_valid[s]), 64'd0);
         check("rst_d", 64'(d[s]), 64'd0);
         check("rst_bo", 64'(bo[s]), 64'd0);
         check("rst_v", 64'(v[s]), 64'd0);
      end

      // Directed cases on the 4-chunk instance.
      do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 0);
      do_op(0, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
      do_op(0, 32'h0000_0100, 32'h0000_0001, 1'b1, 0);
      do_op(0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
      do_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

      // Backpressure with spurious operands offered during DONE.
      do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 6);

      // Random operands.
      for (int i = 0; i < 6; i++) begin
         do_op(0, 32'($urandom), 32'($urandom), 1'($urandom_range(1, 0)), 0);
      end

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      in_valid[0] = 1'b1;
      a[0]        = 32'hDEAD_BEEF;
      b[0]        = 32'h0000_0001;
      bi[0]       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("mid_rst_d", 64'(d[0]), 64'd0);
      check("mid_rst_bo", 64'(bo[0]), 64'd0);
      check("mid_rst_v", 64'(v[0]), 64'd0);
      do_op(0, 32'd9, 32'd4, 1'b0, 0);

      // Single-chunk instance.
      do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
      do_op(1, 32'h0000_0000, 32'h0000_0001, 1'b1, 2);
      do_op(1, 32'($urandom), 32'($urandom), 1'b1, 0);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
